ppu_reg_bank: RTL and testbench
===============================

Name: ppu_reg_bank

Overview:
Parametrised, clocked successor to the PPU FFxx address decoder.
- Decodes a configurable contiguous window of NUM_REGS registers (default FF40..FF4B).
- Holds register storage with per-register write strobes and registered read data.
- Drives a trigger sequencer: a write to one designated register (default FF46, OAM DMA) starts a fixed-length busy count.
- Sits between the CPU bus pages and the PPU/DMA pages, replacing raw one-hot decode lines with storage plus strobes.

Parameters:
BASE_ADDR, 16'hFF40, address of register index 0
NUM_REGS, 12, number of consecutive registers (1..16)
DATA_W, 8, register/bus width
RO_MASK, 12'h010, bit i set = register i is read-only to the CPU (default: FF44/LY)
TRIG_IDX, 6, register index whose write starts the sequencer
TRIG_LEN, 160, sequencer busy length in cycles (>=2)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
a  in  16  CPU address
d_in  in  DATA_W  CPU write data
rd  in  1  read request level
wr  in  1  write request level
sel  out  NUM_REGS  combinational one-hot decode, bit i = (a == BASE_ADDR+i)
d_out  out  DATA_W  registered read data
d_oe  out  1  registered read-data valid / bus drive enable
regs  out  NUM_REGS*DATA_W  flat register contents, index 0 in LSBs
wr_pulse  out  NUM_REGS  one-cycle commit strobe per register
trig_busy  out  1  sequencer active
trig_count  out  $clog2(TRIG_LEN)  current sequencer step
trig_done  out  1  one-cycle pulse on sequencer completion

Behaviour:
- Reset (async, immediate): all registers, d_out, d_oe, wr_pulse, trig_busy, trig_count, trig_done = 0; wr edge detector primed as "wr was high", so a wr held across reset release does not commit.
- Decode: hit = |sel. The comparison is full 16-bit, purely combinational, with no clock latency.
- Write commit:
  - Occurs on the first rising clk edge where wr=1 and the previous-cycle wr=0 (edge-detected; one commit per wr assertion).
  - Address and data are sampled at that edge.
  - Writable register: reg[i] <= d_in and wr_pulse[i] = 1 for exactly the next cycle.
  - RO register or miss: no storage change, no wr_pulse.
- Read: at each edge with rd=1 and hit, d_out <= reg[i] and d_oe <= 1 (latency 1). Otherwise d_oe <= 0 and d_out <= 0.
- rd and wr together on the same register: the read returns the pre-write value (read-before-write).
- Sequencer states IDLE, BUSY, DONE:
  - IDLE -> BUSY on commit to TRIG_IDX; trig_count <= 0, trig_busy <= 1.
  - In BUSY, trig_count increments each cycle. At TRIG_LEN-1 -> DONE.
  - DONE lasts one cycle (trig_done = 1, trig_busy = 0, trig_count held at TRIG_LEN-1) -> IDLE, trig_count <= 0.
  - Commit to TRIG_IDX while in BUSY or DONE restarts BUSY at count 0, with no trig_done for the aborted run.
- Reset mid-run aborts to IDLE with no trig_done.
- Addresses outside the window never disturb state.

Optional Feature:
Macro PPU_REG_EXT_RD_EN.
- Defined:
  - Adds input ext_rd_data (NUM_REGS*DATA_W) and parameter EXT_MASK (default 12'h012, STAT/LY).
  - Reads of register i with EXT_MASK[i]=1 return the ext_rd_data slice instead of storage. Storage is still written if writable.
- Undefined: the port and parameter are absent; all reads return storage.

Decomposition:
- Shared package ppu_reg_pkg: register index localparams (LCDC=0 .. WX=11), default BASE_ADDR, the seq_state_t enum {IDLE, BUSY, DONE}, and a DMA_LEN=160 constant.
- One sub-module, ppu_reg_trig_seq: the sequencer FSM plus counter, driven by a start strobe. Decode, storage and read mux stay in the top level.

Test Plan:
1. Reset asserted mid-cycle with wr=1 held through release -> all outputs 0, no commit until wr drops and re-rises.
2. Write 8'h91 to FF40, then read FF40 -> wr_pulse[0] high one cycle; d_out=8'h91 and d_oe=1 one cycle after rd.
3. Write 8'h55 to FF44 (RO) and to FF4C (miss) -> no wr_pulse, regs unchanged, read FF44 returns 0, read FF4C gives d_oe=0.
4. Write FF46 -> trig_busy for 160 cycles, trig_count 0..159, trig_done pulses once at cycle 161, then IDLE.
5. Rewrite FF46 at count 80 -> count restarts at 0, trig_done occurs exactly 160 busy cycles after the rewrite, only once.
6. Same-cycle rd+wr to FF42 (old 8'h00, new 8'h10) -> d_out=8'h00; a subsequent read gives 8'h10. With PPU_REG_EXT_RD_EN, a read of FF44 returns the ext_rd_data slice.

Source files
------------

// File: rtl/ppu_reg_pkg.sv
// ppu_reg_pkg: shared register indices, default window base, sequencer state type and DMA length
package ppu_reg_pkg;
  localparam int LCDC = 0;
  localparam int STAT = 1;
  localparam int SCY  = 2;
  localparam int SCX  = 3;
  localparam int LY   = 4;
  localparam int LYC  = 5;
  localparam int DMA  = 6;
  localparam int BGP  = 7;
  localparam int OBP0 = 8;
  localparam int OBP1 = 9;
  localparam int WY   = 10;
  localparam int WX   = 11;
  localparam logic [15:0] DEF_BASE_ADDR = 16'hFF40;
  localparam int DMA_LEN = 160;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} seq_state_t;
endpackage

// File: rtl/ppu_reg_trig_seq.sv
// ppu_reg_trig_seq: fixed-length busy sequencer started by a one-cycle strobe
// Ports: clk, reset (async, active-high); i_start restarts the run at count 0;
//   o_busy high for TRIG_LEN cycles, o_count current step, o_done one-cycle completion pulse.
module ppu_reg_trig_seq
  import ppu_reg_pkg::*;
#(
  parameter int TRIG_LEN = DMA_LEN
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_start,
  output logic                        o_busy,
  output logic [$clog2(TRIG_LEN)-1:0] o_count,
  output logic                        o_done
);
  localparam int CW = $clog2(TRIG_LEN);
  localparam logic [CW-1:0] LAST = CW'(TRIG_LEN - 1);
  seq_state_t r_state;
  logic       w_last;
  assign w_last = o_count == LAST;
  assign o_busy = r_state == BUSY;
  assign o_done = r_state == DONE;
  // A start always wins, so a rewrite during BUSY or DONE restarts without a done pulse.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      o_count <= '0;
    end else if (i_start) begin
      r_state <= BUSY;
      o_count <= '0;
    end else if (r_state == BUSY) begin
      r_state <= w_last ? DONE : BUSY;
      o_count <= w_last ? o_count : o_count + 1'b1;
    end else begin
      r_state <= IDLE;
      o_count <= '0;
    end
endmodule

// File: rtl/ppu_reg_bank.sv
// ppu_reg_bank: windowed PPU register file with edge-detected write commit, registered reads and a trigger sequencer
// Ports: clk, reset (async, active-high); a, d_in, rd, wr CPU bus; sel combinational one-hot decode;
//   d_out/d_oe registered read data and valid; regs flat storage (index 0 in LSBs);
//   wr_pulse per-register commit strobe; trig_busy/trig_count/trig_done sequencer status.
// Option PPU_REG_EXT_RD_EN: adds input ext_rd_data and parameter EXT_MASK; masked registers
//   read from ext_rd_data instead of storage.
module ppu_reg_bank
  import ppu_reg_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          NUM_REGS  = 12,
  parameter int          DATA_W    = 8,
  parameter logic [15:0] RO_MASK   = 16'h0010,
`ifdef PPU_REG_EXT_RD_EN
  parameter logic [15:0] EXT_MASK  = 16'h0012,
`endif
  parameter int          TRIG_IDX  = DMA,
  parameter int          TRIG_LEN  = DMA_LEN
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [15:0]                  a,
  input  logic [DATA_W-1:0]            d_in,
  input  logic                         rd,
  input  logic                         wr,
`ifdef PPU_REG_EXT_RD_EN
  input  logic [NUM_REGS*DATA_W-1:0]   ext_rd_data,
`endif
  output logic [NUM_REGS-1:0]          sel,
  output logic [DATA_W-1:0]            d_out,
  output logic                         d_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs,
  output logic [NUM_REGS-1:0]          wr_pulse,
  output logic                         trig_busy,
  output logic [$clog2(TRIG_LEN)-1:0]  trig_count,
  output logic                         trig_done
);
  logic [NUM_REGS*DATA_W-1:0] r_regs;
  logic                       r_wr_q;
  logic                       w_hit;
  logic                       w_commit;
  logic                       w_start;
  logic [NUM_REGS-1:0]        w_wr_hit;
  logic [DATA_W-1:0]          w_rd;
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_dec
    assign sel[g] = a == 16'(BASE_ADDR + g);
  end
  assign w_hit    = |sel;
  assign w_commit = wr & ~r_wr_q;
  assign w_wr_hit = sel & ~RO_MASK[NUM_REGS-1:0];
  assign w_start  = w_commit & w_wr_hit[TRIG_IDX];
  assign regs     = r_regs;
  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (sel[i])
`ifdef PPU_REG_EXT_RD_EN
        w_rd = EXT_MASK[i] ? ext_rd_data[i*DATA_W +: DATA_W] : r_regs[i*DATA_W +: DATA_W];
`else
        w_rd = r_regs[i*DATA_W +: DATA_W];
`endif
  end
  // r_wr_q resets high so a wr held through reset release is not taken as a fresh edge.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_regs   <= '0;
      r_wr_q   <= 1'b1;
      wr_pulse <= '0;
      d_out    <= '0;
      d_oe     <= 1'b0;
    end else begin
      r_wr_q   <= wr;
      wr_pulse <= w_commit ? w_wr_hit : '0;
      for (int i = 0; i < NUM_REGS; i++)
        if (w_commit && w_wr_hit[i]) r_regs[i*DATA_W +: DATA_W] <= d_in;
      d_oe  <= rd & w_hit;
      d_out <= (rd & w_hit) ? w_rd : '0;
    end
  ppu_reg_trig_seq #(.TRIG_LEN(TRIG_LEN)) u_seq (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_start),
    .o_busy  (trig_busy),
    .o_count (trig_count),
    .o_done  (trig_done)
  );
endmodule

// File: tb/tb_ppu_reg_bank.sv
// tb_ppu_reg_bank: table vectors, hand sequences and randomized traffic checked against a behavioural model
module tb_ppu_reg_bank;
  localparam int N = 12;
  localparam logic [15:0] BASE = 16'hFF40;
  localparam int LEN = 160;
  logic clk, reset, rd, wr;
  logic [15:0] a;
  logic [7:0] d_in, d_out;
  logic d_oe, trig_busy, trig_done;
  logic [N-1:0] sel, wr_pulse;
  logic [N*8-1:0] regs;
  logic [7:0] trig_count;
`ifdef PPU_REG_EXT_RD_EN
  logic [N*8-1:0] ext;
`endif
  int n_chk, n_err;
  logic [7:0] m [N];
  bit pwr;
  int t;
  logic [N-1:0] ro, xm;
  typedef struct packed {
    logic [15:0] a; logic [7:0] d; logic rd; logic wr;
    logic [N-1:0] sel; logic [N-1:0] pul; logic oe; logic [7:0] dout;
  } vec_t;
  vec_t tv [14];

  ppu_reg_bank dut (
    .clk(clk), .reset(reset), .a(a), .d_in(d_in), .rd(rd), .wr(wr),
`ifdef PPU_REG_EXT_RD_EN
    .ext_rd_data(ext),
`endif
    .sel(sel), .d_out(d_out), .d_oe(d_oe), .regs(regs), .wr_pulse(wr_pulse),
    .trig_busy(trig_busy), .trig_count(trig_count), .trig_done(trig_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rdval(input int idx);
`ifdef PPU_REG_EXT_RD_EN
    if (xm[idx]) return ext[idx*8 +: 8];
`endif
    return m[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m[i] = 8'h00;
    pwr = 1'b1;
    t = -1;
  endtask

  task automatic rst_chk(input string nm);
    chk({nm, "_oe"}, d_oe, 0);
    chk({nm, "_dout"}, d_out, 0);
    chk({nm, "_pulse"}, wr_pulse, 0);
    chk({nm, "_regs"}, regs, 0);
    chk({nm, "_busy"}, trig_busy, 0);
    chk({nm, "_count"}, trig_count, 0);
    chk({nm, "_done"}, trig_done, 0);
  endtask

  task automatic cyc(input logic [15:0] ia, input logic [7:0] id, input logic ird, input logic iwr);
    int idx;
    bit hit, commit;
    logic [N-1:0] e_sel, e_pul;
    logic e_oe;
    logic [7:0] e_do, e_cnt;
    logic [N*8-1:0] e_regs;
    a = ia; d_in = id; rd = ird; wr = iwr;
    idx = int'(ia) - int'(BASE);
    hit = idx >= 0 && idx < N;
    e_sel = '0; e_pul = '0; e_do = '0;
    if (hit) e_sel[idx] = 1'b1;
    #1;
    chk("sel", sel, e_sel);
    e_oe = ird && hit;
    if (e_oe) e_do = rdval(idx);
    commit = iwr && !pwr;
    pwr = iwr;
    if (commit && hit) begin
      if (!ro[idx]) begin
        m[idx] = id;
        e_pul[idx] = 1'b1;
        if (idx == 6) t = 0;
        else if (t == LEN) t = -1;
        else if (t >= 0) t++;
      end else if (t == LEN) t = -1;
      else if (t >= 0) t++;
    end else if (t == LEN) t = -1;
    else if (t >= 0) t++;
    for (int i = 0; i < N; i++) e_regs[i*8 +: 8] = m[i];
    e_cnt = t < 0 ? 8'd0 : (t < LEN ? 8'(t) : 8'(LEN - 1));
    @(posedge clk);
    #1;
    chk("d_oe", d_oe, e_oe);
    chk("d_out", d_out, e_do);
    chk("wr_pulse", wr_pulse, e_pul);
    chk("regs", regs, e_regs);
    chk("trig_busy", trig_busy, t >= 0 && t < LEN);
    chk("trig_count", trig_count, e_cnt);
    chk("trig_done", trig_done, t == LEN);
  endtask

  task automatic seq_run(input string nm);
    int bn, dn, da;
    bn = int'(trig_busy); dn = int'(trig_done); da = 0;
    for (int k = 2; k <= 170; k++) begin
      cyc(16'h0000, 8'h00, 1'b0, 1'b0);
      bn += int'(trig_busy);
      if (trig_done) begin dn++; da = k; end
    end
    chk({nm, "_busy_cycles"}, bn, LEN);
    chk({nm, "_done_pulses"}, dn, 1);
    chk({nm, "_done_at"}, da, LEN + 1);
  endtask

  initial begin
    int n, dn;
    logic [15:0] ra;
    n_chk = 0; n_err = 0;
    ro = 12'h010; xm = 12'h012;
`ifdef PPU_REG_EXT_RD_EN
    ext = 96'hC1C2_C3C4_C5C6_C7C8_C9CA_CBCC;
`endif
    reset = 1'b0; rd = 1'b0; wr = 1'b1; a = 16'hFF40; d_in = 8'hEE;
    model_reset();
    #2 reset = 1'b1;
    #1 rst_chk("reset_async");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cyc(16'hFF40, 8'hEE, 1'b0, 1'b1);
    chk("held_wr_no_commit", regs[7:0], 8'h00);
    cyc(16'hFF40, 8'hEE, 1'b0, 1'b0);
    cyc(16'hFF40, 8'hEE, 1'b0, 1'b1);
    chk("rerise_commit", regs[7:0], 8'hEE);
    chk("rerise_pulse", wr_pulse, 12'h001);

    tv[0]  = '{16'hFF40, 8'h91, 1'b0, 1'b0, 12'h001, 12'h000, 1'b0, 8'h00};
    tv[1]  = '{16'hFF40, 8'h91, 1'b0, 1'b1, 12'h001, 12'h001, 1'b0, 8'h00};
    tv[2]  = '{16'hFF40, 8'h00, 1'b1, 1'b0, 12'h001, 12'h000, 1'b1, 8'h91};
    tv[3]  = '{16'hFF44, 8'h55, 1'b0, 1'b1, 12'h010, 12'h000, 1'b0, 8'h00};
    tv[4]  = '{16'hFF44, 8'h00, 1'b1, 1'b0, 12'h010, 12'h000, 1'b1, 8'h00};
`ifdef PPU_REG_EXT_RD_EN
    tv[4].dout = ext[39:32];
`endif
    tv[5]  = '{16'hFF4C, 8'h55, 1'b0, 1'b1, 12'h000, 12'h000, 1'b0, 8'h00};
    tv[6]  = '{16'hFF4C, 8'h00, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0, 8'h00};
    tv[7]  = '{16'hFF42, 8'h10, 1'b1, 1'b1, 12'h004, 12'h004, 1'b1, 8'h00};
    tv[8]  = '{16'hFF42, 8'h00, 1'b1, 1'b0, 12'h004, 12'h000, 1'b1, 8'h10};
    tv[9]  = '{16'hFF3F, 8'h77, 1'b1, 1'b1, 12'h000, 12'h000, 1'b0, 8'h00};
    tv[10] = '{16'hFF4B, 8'h77, 1'b0, 1'b0, 12'h800, 12'h000, 1'b0, 8'h00};
    tv[11] = '{16'hFF4B, 8'hA5, 1'b0, 1'b1, 12'h800, 12'h800, 1'b0, 8'h00};
    tv[12] = '{16'hFF4B, 8'h00, 1'b1, 1'b1, 12'h800, 12'h000, 1'b1, 8'hA5};
    tv[13] = '{16'h0000, 8'h00, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 8'h00};
    for (int i = 0; i < 14; i++) begin
      cyc(tv[i].a, tv[i].d, tv[i].rd, tv[i].wr);
      chk($sformatf("tv%0d_sel", i), sel, tv[i].sel);
      chk($sformatf("tv%0d_pulse", i), wr_pulse, tv[i].pul);
      chk($sformatf("tv%0d_oe", i), d_oe, tv[i].oe);
      chk($sformatf("tv%0d_dout", i), d_out, tv[i].dout);
    end
    chk("ro_untouched", regs[39:32], 8'h00);

    cyc(16'hFF46, 8'h01, 1'b0, 1'b1);
    seq_run("dma");

    cyc(16'hFF46, 8'h02, 1'b0, 1'b1);
    n = 0;
    while (trig_count != 8'd80 && n < 200) begin
      cyc(16'h0000, 8'h00, 1'b0, 1'b0);
      n++;
    end
    chk("reach_count80", trig_count, 8'd80);
    cyc(16'hFF46, 8'h03, 1'b0, 1'b1);
    chk("restart_count0", trig_count, 8'd0);
    seq_run("restart");

    for (int i = 0; i < 3000; i++) begin
      ra = ($urandom_range(0, 9) < 8) ? 16'hFF3E + 16'($urandom_range(0, 15)) : 16'($urandom);
      if (ra == 16'hFF46 && $urandom_range(0, 7) != 0) ra = 16'hFF47;
      cyc(ra, 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    cyc(16'h0000, 8'h00, 1'b0, 1'b0);
    cyc(16'hFF46, 8'h04, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cyc(16'h0000, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1 rst_chk("midrun_reset");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(16'h0000, 8'h00, 1'b0, 1'b0);
      dn += int'(trig_done);
    end
    chk("no_done_after_reset", dn, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
